// File: rtl/yutorina_spm_dumper_if.sv
// Control, SPM port-B and byte-stream signals of the SPM dumper.
// The master modport is the dumper's view; slave is the surrounding system.
interface yutorina_spm_dumper_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   word_count;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] spm_addr;
   logic              spm_rd_en;
   logic [31:0]       spm_rd_data;
   logic [7:0]        byte_data;
   logic              byte_valid;
   logic              byte_ready;

   modport master (
      input  start, start_addr, word_count, spm_rd_data, byte_ready,
      output busy, done, spm_addr, spm_rd_en, byte_data, byte_valid
   );

   modport slave (
      output start, start_addr, word_count, spm_rd_data, byte_ready,
      input  busy, done, spm_addr, spm_rd_en, byte_data, byte_valid
   );
endinterface

// File: rtl/yutorina_spm_dumper.sv
// Reads a word range from SPM port B and streams it out MSB-first as bytes.
// Define YUTORINA_DUMP_CHECKSUM_EN to append an 8-bit running-sum trailer byte.
module yutorina_spm_dumper #(
   parameter int ADDR_W = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   yutorina_spm_dumper_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_SEND  = 3'd3,
`ifdef YUTORINA_DUMP_CHECKSUM_EN
      S_TRAIL = 3'd4,
`endif
      S_DONE  = 3'd5
   } state_t;

   state_t            state, state_nxt;

   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W:0]   remain, remain_nxt;
   logic [23:0]       sh, sh_nxt;
   logic [1:0]        idx, idx_nxt;

   logic              busy_r, busy_nxt;
   logic              done_r, done_nxt;
   logic              spm_rd_en_r, spm_rd_en_nxt;
   logic [ADDR_W-1:0] spm_addr_r, spm_addr_nxt;
   logic [7:0]        byte_data_r, byte_data_nxt;
   logic              byte_valid_r, byte_valid_nxt;
`ifdef YUTORINA_DUMP_CHECKSUM_EN
   logic [7:0]        sum, sum_nxt;
`endif

   logic              xfer;
   logic              last_word;

   assign xfer      = byte_valid_r && bus.byte_ready;
   assign last_word = (remain == (ADDR_W+1)'(1));

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = (bus.word_count == '0) ? S_DONE : S_READ;
         end
         S_READ: state_nxt = S_WAIT;
         S_WAIT: state_nxt = S_SEND;
         S_SEND: begin
            if (xfer && idx == 2'd3) begin
               if (!last_word) state_nxt = S_READ;
`ifdef YUTORINA_DUMP_CHECKSUM_EN
               else            state_nxt = S_TRAIL;
`else
               else            state_nxt = S_DONE;
`endif
            end
         end
`ifdef YUTORINA_DUMP_CHECKSUM_EN
         S_TRAIL: if (xfer) state_nxt = S_DONE;
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of every registered output and of the word/byte bookkeeping.
   always_comb begin
      addr_nxt       = addr;
      remain_nxt     = remain;
      sh_nxt         = sh;
      idx_nxt        = idx;
      byte_data_nxt  = byte_data_r;
      byte_valid_nxt = byte_valid_r;
      spm_addr_nxt   = spm_addr_r;
`ifdef YUTORINA_DUMP_CHECKSUM_EN
      sum_nxt        = sum;
`endif
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               addr_nxt   = bus.start_addr;
               remain_nxt = bus.word_count;
`ifdef YUTORINA_DUMP_CHECKSUM_EN
               sum_nxt    = 8'h00;
`endif
            end
         end
         S_WAIT: begin
            byte_data_nxt  = bus.spm_rd_data[31:24];
            sh_nxt         = bus.spm_rd_data[23:0];
            byte_valid_nxt = 1'b1;
            idx_nxt        = 2'd0;
         end
         S_SEND: begin
            if (xfer) begin
`ifdef YUTORINA_DUMP_CHECKSUM_EN
               sum_nxt = sum + byte_data_r;
`endif
               idx_nxt = idx + 2'd1;
               if (idx != 2'd3) begin
                  byte_data_nxt = sh[23:16];
                  sh_nxt        = {sh[15:0], 8'h00};
               end else begin
                  addr_nxt   = addr + ADDR_W'(1);
                  remain_nxt = remain - (ADDR_W+1)'(1);
`ifdef YUTORINA_DUMP_CHECKSUM_EN
                  // Valid stays high so the trailer follows with no bubble.
                  if (last_word) byte_data_nxt  = sum_nxt;
                  else           byte_valid_nxt = 1'b0;
`else
                  byte_valid_nxt = 1'b0;
`endif
               end
            end
         end
`ifdef YUTORINA_DUMP_CHECKSUM_EN
         S_TRAIL: if (xfer) byte_valid_nxt = 1'b0;
`endif
         default: ;
      endcase

      if (state_nxt == S_READ) spm_addr_nxt = addr_nxt;
      spm_rd_en_nxt = (state_nxt == S_READ);
      busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_nxt      = (state_nxt == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         spm_rd_en_r  <= 1'b0;
         spm_addr_r   <= '0;
         byte_data_r  <= 8'h00;
         byte_valid_r <= 1'b0;
`ifdef YUTORINA_DUMP_CHECKSUM_EN
         sum          <= 8'h00;
`endif
      end else begin
         busy_r       <= busy_nxt;
         done_r       <= done_nxt;
         spm_rd_en_r  <= spm_rd_en_nxt;
         spm_addr_r   <= spm_addr_nxt;
         byte_data_r  <= byte_data_nxt;
         byte_valid_r <= byte_valid_nxt;
`ifdef YUTORINA_DUMP_CHECKSUM_EN
         sum          <= sum_nxt;
`endif
      end
   end

   // Bookkeeping only matters once a start is accepted, so it needs no reset.
   always_ff @(posedge clock) begin
      addr   <= addr_nxt;
      remain <= remain_nxt;
      sh     <= sh_nxt;
      idx    <= idx_nxt;
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.spm_rd_en  = spm_rd_en_r;
   assign bus.spm_addr   = spm_addr_r;
   assign bus.byte_data  = byte_data_r;
   assign bus.byte_valid = byte_valid_r;

endmodule

// File: tb/tb_yutorina_spm_dumper.sv
// Bench for yutorina_spm_dumper: vector table plus scoreboard of expected SPM
// addresses and bytes; also handles a YUTORINA_DUMP_CHECKSUM_EN build.
module tb_yutorina_spm_dumper;
   localparam int ADDR_W = 12;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   yutorina_spm_dumper_if #(.ADDR_W(ADDR_W)) bus ();
   yutorina_spm_dumper #(.ADDR_W(ADDR_W)) dut (.clock(clock), .reset(reset), .bus(bus));

   logic [31:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clock) if (bus.spm_rd_en) bus.spm_rd_data <= mem[bus.spm_addr];

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W:0]   cnt;
      logic [31:0]       w0;
      logic [31:0]       w1;
      int                nbytes;
      logic              rnd;
   } vec_t;
   vec_t vecs [5];

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int popped = 0;
   logic [7:0] byte_q [$];
   logic [ADDR_W-1:0] addr_q [$];
   logic [7:0] exp_sum = 8'h00;
   logic stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask
   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask
   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      chk(name, {24'b0, act}, {24'b0, exp});
   endtask

   // Sample at the falling edge, then return just after the next rising edge.
   task automatic monitor();
      if (stall_prev) begin
         chk1("hold_valid", bus.byte_valid, 1'b1);
         chk8("hold_data", bus.byte_data, stall_data);
      end
      if (bus.byte_valid && bus.byte_ready && !reset) begin
         checks++;
         if (byte_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %0h required none", bus.byte_data);
         end else begin
            logic [7:0] e;
            e = byte_q.pop_front();
            if (bus.byte_data !== e) begin
               errors++;
               $display("FAIL byte: got %0h required %0h", bus.byte_data, e);
            end
         end
         popped++;
      end
      if (bus.spm_rd_en && !reset) begin
         checks++;
         if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: got %0h required none", bus.spm_addr);
         end else begin
            logic [ADDR_W-1:0] ea;
            ea = addr_q.pop_front();
            if (bus.spm_addr !== ea) begin
               errors++;
               $display("FAIL spm_addr: got %0h required %0h", bus.spm_addr, ea);
            end
         end
      end
      if (bus.done) begin
         done_cnt++;
         chk1("busy_at_done", bus.busy, 1'b0);
      end
      stall_prev = bus.byte_valid && !bus.byte_ready && !reset;
      stall_data = bus.byte_data;
   endtask

   task automatic tick();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int b = 3; b >= 0; b--) begin
         byte_q.push_back(w[b*8 +: 8]);
         exp_sum = exp_sum + w[b*8 +: 8];
      end
   endtask

   task automatic push_trailer();
`ifdef YUTORINA_DUMP_CHECKSUM_EN
      byte_q.push_back(exp_sum);
`endif
   endtask

   task automatic prep(input logic [ADDR_W-1:0] a, input int n);
      exp_sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         logic [ADDR_W-1:0] ai;
         ai = a + ADDR_W'(i);
         addr_q.push_back(ai);
         push_word(mem[ai]);
      end
      if (n != 0) push_trailer();
   endtask

   task automatic start_dump(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
      bus.start      = 1'b1;
      bus.start_addr = a;
      bus.word_count = n;
      tick();
      bus.start      = 1'b0;
   endtask

   task automatic wait_done(input int budget, input logic rnd);
      int d0;
      int k;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt == d0 && k < budget) begin
         bus.byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         k++;
      end
      chk("done_seen", done_cnt - d0, 1);
      chk("byte_q_empty", byte_q.size(), 0);
      chk("addr_q_empty", addr_q.size(), 0);
   endtask

   initial begin
      int p0;
      int d0;
      int k;
      int exp_n;

      vecs[0] = '{addr: 12'h010, cnt: 13'd1, w0: 32'h11223344, w1: 32'h0,        nbytes: 4, rnd: 1'b0};
      vecs[1] = '{addr: 12'h020, cnt: 13'd0, w0: 32'h55555555, w1: 32'h0,        nbytes: 0, rnd: 1'b0};
      vecs[2] = '{addr: 12'hFFF, cnt: 13'd2, w0: 32'hDEADBEEF, w1: 32'h01020304, nbytes: 8, rnd: 1'b0};
      vecs[3] = '{addr: 12'h100, cnt: 13'd2, w0: 32'h80FF7F00, w1: 32'hA55A5AA5, nbytes: 8, rnd: 1'b1};
      vecs[4] = '{addr: 12'h7FE, cnt: 13'd1, w0: 32'hFFFFFFFF, w1: 32'h0,        nbytes: 4, rnd: 1'b1};

      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h5A000000 | i;
      bus.start       = 1'b0;
      bus.start_addr  = '0;
      bus.word_count  = '0;
      bus.byte_ready  = 1'b1;
      bus.spm_rd_data = 32'h0;

      reset = 1'b1;
      tick();
      tick();
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_valid", bus.byte_valid, 1'b0);
      chk8("rst_data", bus.byte_data, 8'h00);
      chk1("rst_rd_en", bus.spm_rd_en, 1'b0);
      chk("rst_spm_addr", 32'(bus.spm_addr), 32'h0);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         mem[vecs[v].addr] = vecs[v].w0;
         mem[vecs[v].addr + ADDR_W'(1)] = vecs[v].w1;
         prep(vecs[v].addr, int'(vecs[v].cnt));
         exp_n = vecs[v].nbytes;
`ifdef YUTORINA_DUMP_CHECKSUM_EN
         if (vecs[v].cnt != 0) exp_n++;
`endif
         p0 = popped;
         start_dump(vecs[v].addr, vecs[v].cnt);
         wait_done(200, vecs[v].rnd);
         chk("nbytes", popped - p0, exp_n);
         tick();
      end

      // First-transaction latency and end-of-dump timing.
      mem[12'h010] = 32'h11223344;
      prep(12'h010, 1);
      bus.byte_ready = 1'b1;
      start_dump(12'h010, 13'd1);
      chk1("lat_rd_en_e0", bus.spm_rd_en, 1'b1);
      chk("lat_spm_addr", 32'(bus.spm_addr), 32'h010);
      chk1("lat_busy_e0", bus.busy, 1'b1);
      chk1("lat_valid_e0", bus.byte_valid, 1'b0);
      tick();
      chk1("lat_rd_en_e1", bus.spm_rd_en, 1'b0);
      chk1("lat_valid_e1", bus.byte_valid, 1'b0);
      tick();
      chk1("lat_valid_e2", bus.byte_valid, 1'b1);
      chk8("lat_data_e2", bus.byte_data, 8'h11);
      repeat (4) tick();
`ifdef YUTORINA_DUMP_CHECKSUM_EN
      chk1("trail_valid", bus.byte_valid, 1'b1);
      chk8("trail_sum", bus.byte_data, 8'hAA);
`else
      chk1("done_after_last", bus.done, 1'b1);
`endif
      wait_done(20, 1'b0);
      tick();

      // Zero-word dump: done on the cycle after start, nothing else.
      start_dump(12'h020, 13'd0);
      chk1("zero_done", bus.done, 1'b1);
      chk1("zero_busy", bus.busy, 1'b0);
      chk1("zero_rd_en", bus.spm_rd_en, 1'b0);
      chk1("zero_valid", bus.byte_valid, 1'b0);
      wait_done(5, 1'b0);
      repeat (3) tick();

      // Back-pressure on 0x22 with start pulses that must be ignored.
      prep(12'h010, 1);
      start_dump(12'h010, 13'd1);
      tick();
      tick();
      tick();
      chk8("stall_first", bus.byte_data, 8'h22);
      bus.byte_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         bus.start      = 1'b1;
         bus.start_addr = 12'h300;
         bus.word_count = 13'd3;
         tick();
         chk8("stall_data", bus.byte_data, 8'h22);
         chk1("stall_valid", bus.byte_valid, 1'b1);
      end
      bus.start = 1'b0;
      wait_done(30, 1'b0);
      d0 = done_cnt;
      repeat (12) tick();
      chk("no_queued_start", done_cnt - d0, 0);
      chk1("idle_after_stall", bus.busy, 1'b0);

      // Reset while the third byte of a 4-word dump is valid.
      mem[12'h200] = 32'hA0A1A2A3;
      mem[12'h201] = 32'hB0B1B2B3;
      mem[12'h202] = 32'hC0C1C2C3;
      mem[12'h203] = 32'hD0D1D2D3;
      prep(12'h200, 4);
      p0 = popped;
      start_dump(12'h200, 13'd4);
      k = 0;
      while (popped - p0 < 2 && k < 30) begin
         tick();
         k++;
      end
      chk("rst_reach_byte3", popped - p0, 2);
      chk8("rst_byte3", bus.byte_data, 8'hA2);
      reset = 1'b1;
      bus.byte_ready = 1'b0;
      tick();
      reset = 1'b0;
      bus.byte_ready = 1'b1;
      chk1("mid_rst_valid", bus.byte_valid, 1'b0);
      chk1("mid_rst_busy", bus.busy, 1'b0);
      chk1("mid_rst_done", bus.done, 1'b0);
      chk1("mid_rst_rd_en", bus.spm_rd_en, 1'b0);
      chk8("mid_rst_data", bus.byte_data, 8'h00);
      byte_q.delete();
      addr_q.delete();
      d0 = done_cnt;
      repeat (20) tick();
      chk("no_done_after_rst", done_cnt - d0, 0);

      prep(12'h010, 1);
      start_dump(12'h010, 13'd1);
      tick();
      tick();
      chk8("fresh_first", bus.byte_data, 8'h11);
      wait_done(30, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/yutorina_spm_dumper.md
# yutorina_spm_dumper

Read-side counterpart to the simulation-time SPM load: a hardware engine that reads a contiguous range of 32-bit words out of the scratch-pad memory (SPM) through its second port and streams them out as bytes over a valid/ready interface. It sits beside `yutorina_cpu`, attaches to the dual-port SPM port B, and feeds a byte sink such as a UART transmitter or a bench monitor. It is used to extract memory images after a run, with no CPU involvement.

## Interface
- `ADDR_W`, default 12: SPM word-address width.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a dump; sampled only in IDLE.
- `start_addr` in ADDR_W: first word address; captured when `start` is accepted.
- `word_count` in ADDR_W+1: number of words to dump, 0 to 2^ADDR_W; captured when `start` is accepted.
- `busy` out 1: high from the edge that accepts `start` until the edge `done` asserts.
- `done` out 1: one-cycle pulse at the end of a dump.
- `spm_addr` out ADDR_W: SPM port-B word address (registered).
- `spm_rd_en` out 1: SPM port-B read strobe (registered).
- `spm_rd_data` in 32: SPM port-B read data; valid the cycle after `spm_rd_en`.
- `byte_data` out 8: output byte.
- `byte_valid` out 1: `byte_data` is valid.
- `byte_ready` in 1: sink accepts the byte; a transfer occurs on an edge where `byte_valid && byte_ready`.

## Operation
- FSM states: IDLE, READ, WAIT, SEND, TRAIL, DONE.
- IDLE:
  - `start` high with `word_count`≠0: capture the address and count, then go to READ.
  - `start` high with `word_count`=0: go to DONE; no SPM read and no byte is emitted.
- READ: drive `spm_rd_en`=1 and `spm_addr`=current address for exactly one cycle, then go to WAIT.
- WAIT: `spm_rd_en`=0. On the next edge, load `spm_rd_data` into a 32-bit shift register, set `byte_valid`=1, set byte index to 0, and go to SEND.
- SEND:
  - Bytes are emitted MSB first: [31:24], [23:16], [15:8], [7:0].
  - Each transfer advances the byte index.
  - After the transfer of byte 3:
    - decrement the remaining count and increment the address;
    - if words remain, drop `byte_valid` and go to READ;
    - otherwise go to TRAIL if `YUTORINA_DUMP_CHECKSUM_EN` is defined, else go to DONE.
- TRAIL: emit one checksum byte under the same handshake, then go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. A dump running past the top address wraps to 0.
- `start` outside IDLE is ignored, with no queueing.

## Timing
- Reset values: `busy`=0, `done`=0, `byte_valid`=0, `byte_data`=0x00, `spm_rd_en`=0, `spm_addr`=0, FSM=IDLE, checksum=0.
- `start` sampled at edge E0 → `spm_rd_en`=1 after E0 → read data captured at E2 → `byte_valid`=1 after E2.
- Sustained throughput with `byte_ready` held high: 4 bytes per 6 cycles.
- While `byte_valid && !byte_ready`, `byte_data` and `byte_valid` hold stable.
- `byte_valid` never deasserts without a transfer, except on `reset`.
- `byte_ready` may change freely and has no combinational path to any output.
- Reset asserted mid-dump: every output returns to its reset value at that edge. No partial byte or `done` is produced afterwards.
- `done` and a new `start` cannot coincide. `start` is only honoured in IDLE, i.e. from the cycle after `done`.

## Configuration
- `YUTORINA_DUMP_CHECKSUM_EN` defined:
  - an 8-bit running sum (mod 256) of every transferred byte of the current dump is kept;
  - the sum clears when `start` is accepted;
  - after the last data byte, the sum is emitted as one extra byte in TRAIL;
  - a zero-word dump emits no trailer.
- Undefined: TRAIL and the checksum register are not compiled; the stream is exactly 4×`word_count` bytes.

## Test plan
- SPM[0x010]=0x11223344; `start_addr`=0x010, `word_count`=1, `byte_ready`=1 → bytes 0x11,0x22,0x33,0x44, then `done` one cycle later. With `_EN`, 0xAA precedes `done`.
- `word_count`=0 → `done` pulses on the cycle after start; `spm_rd_en` and `byte_valid` stay 0.
- SPM[0xFFF]=0xDEADBEEF, SPM[0x000]=0x01020304, `start_addr`=0xFFF, `word_count`=2 → `spm_addr` sequence 0xFFF then 0x000; 8 bytes DE AD BE EF 01 02 03 04.
- `byte_ready` low for 5 cycles while byte 0x22 is valid → `byte_data` holds 0x22 and no byte is skipped or duplicated; second `start` pulses during the dump are ignored.
- `reset` asserted for one cycle at the third byte of a 4-word dump → `byte_valid`=0, `busy`=0, `done` never pulses. A fresh dump from 0x010 afterwards starts from the first byte again.
